// File: rtl/mux_pkg.sv
// Shared definitions for the mux/demux family: lane count, lane select type,
// and the occupancy-counter width helper.
package mux_pkg;

  localparam int NUM_LANES = 4;

  typedef logic [1:0] lane_sel_t;

  // A counter that must hold 0..depth inclusive needs one bit more than a pointer.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/demux1_4_buf_lane_fifo.sv
// Single-lane FIFO for the 1:4 demux. Full/empty are taken from the occupancy
// count, so the power-of-2 pointers simply wrap.
module lane_fifo
  import mux_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      push,
  input  logic [WIDTH-1:0]          push_data,
  input  logic                      pop,
  output logic [WIDTH-1:0]          head_data,
  output logic [cnt_w(DEPTH)-1:0]   count,
  output logic                      full,
  output logic                      empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;
  logic             do_push;
  logic             do_pop;

  assign full      = (cnt_q == CW'(DEPTH));
  assign empty     = (cnt_q == '0);
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign count     = cnt_q;
  assign head_data = mem_q[rd_ptr_q];

  always_comb begin
    cnt_d = cnt_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Storage is cleared on reset so the head reads 0 rather than stale data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/demux1_4_buf.sv
// Registered, flow-controlled 1:4 demultiplexer: steers each accepted word into
// one of four independent lane FIFOs, each drained by its own valid/ready port.
module demux1_4_buf
  import mux_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [1:0]                            in_sel,
  input  logic [WIDTH-1:0]                      in_data,
  output logic [NUM_LANES-1:0]                  out_valid,
  input  logic [NUM_LANES-1:0]                  out_ready,
  output logic [NUM_LANES-1:0][WIDTH-1:0]       out_data,
  output logic [NUM_LANES-1:0][cnt_w(DEPTH)-1:0] lane_count,
  output logic                                  busy
);

  logic [NUM_LANES-1:0] full_w;
  logic [NUM_LANES-1:0] empty_w;
  logic [NUM_LANES-1:0] push_w;
  logic                 accept;

  // Ready looks only at registered fullness, never at out_ready.
  assign in_ready  = !full_w[in_sel];
  assign accept    = in_valid && in_ready;
  assign out_valid = ~empty_w;
  assign busy      = |out_valid;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    assign push_w[g] = accept && (in_sel == lane_sel_t'(g));

    lane_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (push_w[g]),
      .push_data (in_data),
      .pop       (out_ready[g]),
      .head_data (out_data[g]),
      .count     (lane_count[g]),
      .full      (full_w[g]),
      .empty     (empty_w[g])
    );
  end

endmodule

// File: tb/tb_demux1_4_buf.sv
// Directed and randomized checks for demux1_4_buf against hand values and a
// per-lane queue model.
module tb_demux1_4_buf;

  localparam int WIDTH = 64;
  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic                     clk;
  logic                     reset_n;
  logic                     in_valid;
  logic                     in_ready;
  logic [1:0]               in_sel;
  logic [WIDTH-1:0]         in_data;
  logic [3:0]               out_valid;
  logic [3:0]               out_ready;
  logic [3:0][WIDTH-1:0]    out_data;
  logic [3:0][CW-1:0]       lane_count;
  logic                     busy;

  int n_checks;
  int n_errors;

  logic [63:0] sbq [4][$];

  demux1_4_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sel     (in_sel),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .lane_count (lane_count),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One model-checked cycle: inputs already driven by the caller.
  task automatic cyc();
    bit exp_rdy;
    #1;
    exp_rdy = (sbq[in_sel].size() < DEPTH);
    chk("in_ready", 64'(in_ready), 64'(exp_rdy));
    for (int i = 0; i < 4; i++) begin
      chk("out_valid", 64'(out_valid[i]), 64'(sbq[i].size() != 0));
      chk("lane_count", 64'(lane_count[i]), 64'(sbq[i].size()));
      if (sbq[i].size() != 0) chk("out_data", out_data[i], sbq[i][0]);
    end
    chk("busy", 64'(busy), 64'((sbq[0].size() + sbq[1].size() + sbq[2].size() + sbq[3].size()) != 0));
    for (int i = 0; i < 4; i++)
      if (out_ready[i] && sbq[i].size() != 0) void'(sbq[i].pop_front());
    if (in_valid && exp_rdy) sbq[in_sel].push_back(in_data);
    step();
  endtask

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b1;
    in_sel    = 2'd0;
    in_data   = 64'hFF;
    out_ready = 4'b0000;
    n_checks  = 0;
    n_errors  = 0;

    // Reset held with a word offered
    step();
    step();
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_in_ready", 64'(in_ready), 64'h1);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_lane_count", 64'(lane_count), 64'h0);
    in_valid = 1'b0;
    reset_n  = 1'b1;

    // Route one word to each lane
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_sel   = 2'(i);
      in_data  = 64'hA0 + 64'(i);
      #1;
      chk("route_in_ready", 64'(in_ready), 64'h1);
      step();
    end
    in_valid = 1'b0;
    #1;
    chk("route_out_valid", 64'(out_valid), 64'hF);
    chk("route_busy", 64'(busy), 64'h1);
    for (int i = 0; i < 4; i++) begin
      chk("route_data", out_data[i], 64'hA0 + 64'(i));
      chk("route_count", 64'(lane_count[i]), 64'h1);
    end
    out_ready = 4'b1111;
    step();
    out_ready = 4'b0000;
    #1;
    chk("route_drained", 64'(out_valid), 64'h0);

    // Full lane backpressure on lane 2
    in_valid = 1'b1;
    in_sel   = 2'd2;
    in_data  = 64'h11;
    step();
    in_data = 64'h22;
    step();
    in_data = 64'h33;
    #1;
    chk("full_in_ready", 64'(in_ready), 64'h0);
    chk("full_count", 64'(lane_count[2]), 64'h2);
    out_ready = 4'b0100;
    #1;
    chk("full_no_bypass", 64'(in_ready), 64'h0);
    chk("full_head", out_data[2], 64'h11);
    step();
    out_ready = 4'b0000;
    #1;
    chk("full_after_pop_count", 64'(lane_count[2]), 64'h1);
    chk("full_after_pop_head", out_data[2], 64'h22);
    chk("full_ready_again", 64'(in_ready), 64'h1);
    step();
    in_valid = 1'b0;
    #1;
    chk("full_refill_count", 64'(lane_count[2]), 64'h2);
    chk("drain_first", out_data[2], 64'h22);
    out_ready = 4'b0100;
    step();
    chk("drain_second", out_data[2], 64'h33);
    step();
    chk("drain_empty", 64'(out_valid), 64'h0);
    out_ready = 4'b0000;

    // Concurrent push and pop on lane 1 at count 1
    in_valid = 1'b1;
    in_sel   = 2'd1;
    in_data  = 64'h100;
    cyc();
    for (int k = 0; k < 20; k++) begin
      in_data   = 64'h200 + 64'(k);
      out_ready = 4'b0010;
      cyc();
      chk("conc_count", 64'(lane_count[1]), 64'h1);
    end
    in_valid  = 1'b0;
    out_ready = 4'b0010;
    cyc();
    out_ready = 4'b0000;

    // Asynchronous reset mid-operation
    in_valid = 1'b1;
    in_sel = 2'd0; in_data = 64'hDEAD; cyc();
    in_sel = 2'd3; in_data = 64'hBEEF; cyc();
    in_sel = 2'd0; in_data = 64'hCAFE; cyc();
    in_valid = 1'b0;
    #3;
    reset_n = 1'b0;
    #1;
    chk("mrst_out_valid", 64'(out_valid), 64'h0);
    chk("mrst_busy", 64'(busy), 64'h0);
    chk("mrst_count", 64'(lane_count), 64'h0);
    chk("mrst_data0", out_data[0], 64'h0);
    chk("mrst_data3", out_data[3], 64'h0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) sbq[i].delete();
    in_valid = 1'b1; in_sel = 2'd0; in_data = 64'h5555; cyc();
    in_valid = 1'b0; cyc();
    chk("mrst_new_head", out_data[0], 64'h5555);

    // Random traffic
    for (int k = 0; k < 1000; k++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_sel    = 2'($urandom_range(0, 3));
      in_data   = {$urandom, $urandom};
      out_ready = 4'($urandom_range(0, 15));
      cyc();
    end
    in_valid  = 1'b0;
    out_ready = 4'b1111;
    for (int k = 0; k < DEPTH + 1; k++) cyc();
    chk("final_busy", 64'(busy), 64'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
